// File: rtl/ram_port_arbiter_if.sv
// DDR user command port bundle shared by the frame read and write paths.
// master = arbiter side, slave = memory controller side.
`timescale 1ns/1ps

interface ram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 768
);

    logic              mem_cmd;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_cmd,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_done,
        input  mem_rdata
    );

    modport slave (
        input  mem_cmd,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_done,
        output mem_rdata
    );

endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one DDR command port between the frame
// reader and the frame writer; one grant = one fixed-length burst.
`timescale 1ns/1ps

module ram_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 768,
    parameter int BURST_LEN = 8,
    parameter int ADDR_STEP = 96,
    parameter int TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              phy_init_done,
    input  logic              ram_init,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    ram_port_arbiter_if.master mem,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam int BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BURST_LEN - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t            state;
    logic [BC_W-1:0]   beat_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic [ADDR_W-1:0] cur_addr;
    logic              is_wr;
    logic              last_wr;

    logic mem_ready;
    logic pick_wr;
    logic any_req;
    logic last_beat;
    logic wd_expired;

    // Decode arbitration choice and end-of-burst / watchdog conditions.
    always_comb begin
        mem_ready  = phy_init_done & ram_init;
        any_req    = rd_req | wr_req;
        // Writer wins when alone, or on a tie when the reader went last.
        pick_wr    = wr_req & (~rd_req | ~last_wr);
        last_beat  = (beat_cnt == LAST_BEAT);
        wd_expired = (wd_cnt == WD_LAST);
    end

    // Burst FSM: grant in IDLE, one command per beat, wait for completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            beat_cnt      <= '0;
            wd_cnt        <= '0;
            cur_addr      <= '0;
            is_wr         <= 1'b0;
            last_wr       <= 1'b1;
            grant         <= 2'b00;
            timeout_err   <= 1'b0;
            rd_ready      <= 1'b0;
            rd_data       <= '0;
            wr_ready      <= 1'b0;
            mem.mem_cmd   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            mem.mem_cmd <= 1'b0;
            rd_ready    <= 1'b0;
            wr_ready    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (mem_ready && any_req) begin
                        grant      <= pick_wr ? 2'b10 : 2'b01;
                        is_wr      <= pick_wr;
                        mem.mem_we <= pick_wr;
                        cur_addr   <= pick_wr ? wr_addr : rd_addr;
                        beat_cnt   <= '0;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!mem_ready) begin
                        grant <= 2'b00;
                        state <= S_IDLE;
                    end else begin
                        mem.mem_cmd  <= 1'b1;
                        mem.mem_addr <= cur_addr;
                        if (is_wr) begin
                            mem.mem_wdata <= wr_data;
                        end
                        wd_cnt <= '0;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!mem_ready) begin
                        // Memory lost calibration: drop the burst silently.
                        grant <= 2'b00;
                        state <= S_IDLE;
                    end else if (mem.mem_done) begin
                        if (is_wr) begin
                            wr_ready <= 1'b1;
                        end else begin
                            rd_ready <= 1'b1;
                            rd_data  <= mem.mem_rdata;
                        end
                        if (last_beat) begin
                            last_wr <= is_wr;
                            grant   <= 2'b00;
                            state   <= S_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + BC_W'(1);
                            cur_addr <= cur_addr + STEP;
                            state    <= S_ISSUE;
                        end
                    end else if (wd_expired) begin
                        // Beat lost; hand the next tie to the other side.
                        timeout_err <= 1'b1;
                        last_wr     <= is_wr;
                        grant       <= 2'b00;
                        state       <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: begin
                    grant <= 2'b00;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
